// File: rtl/hansen_mem_arbiter_if.sv
// Request/response bundle between the core's D and I ports,
// the arbiter and the unified single-port memory.
interface hansen_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              d_req_valid;
  logic              d_req_ready;
  logic              d_req_we;
  logic [ADDR_W-1:0] d_req_addr;
  logic [DATA_W-1:0] d_req_wdata;
  logic              d_rsp_valid;
  logic [DATA_W-1:0] d_rsp_rdata;
  logic              i_req_valid;
  logic              i_req_ready;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_rsp_valid;
  logic [DATA_W-1:0] i_rsp_rdata;
  logic              m_req_valid;
  logic              m_req_ready;
  logic              m_req_we;
  logic [ADDR_W-1:0] m_req_addr;
  logic [DATA_W-1:0] m_req_wdata;
  logic              m_rsp_valid;
  logic [DATA_W-1:0] m_rsp_rdata;

  modport slave (
    input  d_req_valid, d_req_we, d_req_addr, d_req_wdata,
    output d_req_ready, d_rsp_valid, d_rsp_rdata,
    input  i_req_valid, i_req_addr,
    output i_req_ready, i_rsp_valid, i_rsp_rdata,
    output m_req_valid, m_req_we, m_req_addr, m_req_wdata,
    input  m_req_ready, m_rsp_valid, m_rsp_rdata
  );

  modport master (
    output d_req_valid, d_req_we, d_req_addr, d_req_wdata,
    input  d_req_ready, d_rsp_valid, d_rsp_rdata,
    output i_req_valid, i_req_addr,
    input  i_req_ready, i_rsp_valid, i_rsp_rdata,
    input  m_req_valid, m_req_we, m_req_addr, m_req_wdata,
    output m_req_ready, m_rsp_valid, m_rsp_rdata
  );
endinterface

// File: rtl/hansen_mem_arbiter.sv
// D/I memory arbiter: grant lock under backpressure, fetch
// starvation guard, in-order response routing via a tag FIFO.
module hansen_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_OUT      = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  hansen_mem_arbiter_if.slave      bus,
  output logic [$clog2(MAX_OUT):0] outstanding,
  output logic                     rsp_err
);

  localparam int PW = $clog2(MAX_OUT);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOCK_D = 2'd1;
  localparam logic [1:0] ST_LOCK_I = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nx;
  logic [CW-1:0]      r_cnt;
  logic [PW-1:0]      r_wptr;
  logic [PW-1:0]      r_rptr;
  logic [MAX_OUT-1:0] r_tags;
  logic [SW-1:0]      r_starve;
  logic               r_err;

  logic w_full;
  logic w_d_elig;
  logic w_i_elig;
  logic w_starved;
  logic w_gnt_d;
  logic w_gnt_i;
  logic w_m_valid;
  logic w_d_ready;
  logic w_i_ready;
  logic w_push;
  logic w_pop;
  logic w_head;

  // Fullness only ever looks at the registered count, so a
  // same-cycle pop does not free a slot until the next cycle.
  assign w_full    = (r_cnt == CW'(MAX_OUT));
  assign w_d_elig  = bus.d_req_valid & (bus.d_req_we | ~w_full);
  assign w_i_elig  = bus.i_req_valid & ~w_full;
  assign w_starved = bus.i_req_valid &
                     (r_starve == SW'(STARVE_LIMIT));

  // Grant selection: locked owner, else D first unless I starved
  always_comb begin
    w_gnt_d = 1'b0;
    w_gnt_i = 1'b0;
    case (r_state)
      ST_LOCK_D: w_gnt_d = 1'b1;
      ST_LOCK_I: w_gnt_i = 1'b1;
      default: begin
        w_gnt_i = w_i_elig & (~w_d_elig | w_starved);
        w_gnt_d = w_d_elig & ~w_gnt_i;
      end
    endcase
  end

  assign w_m_valid = (w_gnt_d & w_d_elig) |
                     (w_gnt_i & w_i_elig);
  assign w_d_ready = w_gnt_d & w_d_elig & bus.m_req_ready;
  assign w_i_ready = w_gnt_i & w_i_elig & bus.m_req_ready;

  assign bus.m_req_valid = w_m_valid;
  assign bus.d_req_ready = w_d_ready;
  assign bus.i_req_ready = w_i_ready;

  // Request mux: fetches are reads with zero write data
  always_comb begin
    bus.m_req_we    = 1'b0;
    bus.m_req_addr  = '0;
    bus.m_req_wdata = '0;
    if (w_gnt_i) begin
      bus.m_req_addr = bus.i_req_addr;
    end else if (w_gnt_d) begin
      bus.m_req_we    = bus.d_req_we;
      bus.m_req_addr  = bus.d_req_addr;
      bus.m_req_wdata = bus.d_req_wdata;
    end
  end

  // Grant FSM next state; a dropped valid while locked unlocks
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_LOCK_D: begin
        if (!bus.d_req_valid || (w_m_valid && bus.m_req_ready))
          w_state_nx = ST_IDLE;
      end
      ST_LOCK_I: begin
        if (!bus.i_req_valid || (w_m_valid && bus.m_req_ready))
          w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx = ST_IDLE;
        if (w_m_valid && !bus.m_req_ready)
          w_state_nx = w_gnt_i ? ST_LOCK_I : ST_LOCK_D;
      end
    endcase
  end

  // Grant state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nx;
  end

  assign w_push = (w_d_ready & ~bus.d_req_we) | w_i_ready;
  assign w_pop  = bus.m_rsp_valid & (r_cnt != '0);
  assign w_head = r_tags[r_rptr];

  // Tag FIFO: 0 = D, 1 = I; stray responses leave it untouched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_tags <= '0;
    end else begin
      if (w_push) begin
        r_tags[r_wptr] <= w_gnt_i;
        r_wptr         <= r_wptr + 1'b1;
      end
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // Sticky error for a response with nothing outstanding
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_err <= 1'b0;
    else if (bus.m_rsp_valid && r_cnt == '0)
      r_err <= 1'b1;
  end

  // Fetch starvation counter, saturating at the limit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve <= '0;
    end else if (bus.i_req_valid && !w_i_ready) begin
      if (r_starve != SW'(STARVE_LIMIT))
        r_starve <= r_starve + 1'b1;
    end else begin
      r_starve <= '0;
    end
  end

  assign bus.d_rsp_valid = w_pop & ~w_head;
  assign bus.i_rsp_valid = w_pop & w_head;
  assign bus.d_rsp_rdata = bus.m_rsp_rdata;
  assign bus.i_rsp_rdata = bus.m_rsp_rdata;

  assign outstanding = r_cnt;
  assign rsp_err     = r_err;

endmodule

// File: tb/tb_hansen_mem_arbiter.sv
// Bench for hansen_mem_arbiter: directed scenarios followed by
// randomized traffic checked against a queue-based model.
module tb_hansen_mem_arbiter;

  localparam int MAX_OUT = 4;
  localparam int LIM     = 8;

  logic       clk;
  logic       reset;
  logic [2:0] outstanding;
  logic       rsp_err;

  int n_tests;
  int n_fail;

  hansen_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

  hansen_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32),
    .MAX_OUT(MAX_OUT), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave),
    .outstanding(outstanding),
    .rsp_err(rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.d_req_valid = 1'b0;
    bus.d_req_we    = 1'b0;
    bus.d_req_addr  = '0;
    bus.d_req_wdata = '0;
    bus.i_req_valid = 1'b0;
    bus.i_req_addr  = '0;
    bus.m_req_ready = 1'b0;
    bus.m_rsp_valid = 1'b0;
    bus.m_rsp_rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    #1;
    n_tests++; if (bus.m_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mvalid got %0b exp 0", bus.m_req_valid); end
    n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL rst_out got %0d exp 0", outstanding); end
    n_tests++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %0b exp 0", rsp_err); end
    n_tests++; if ({bus.d_req_ready, bus.i_req_ready, bus.d_rsp_valid, bus.i_rsp_valid} !== 4'b0) begin n_fail++; $display("FAIL rst_flags got %b exp 0000", {bus.d_req_ready, bus.i_req_ready, bus.d_rsp_valid, bus.i_rsp_valid}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    bus.i_req_valid = 1'b1;
    bus.i_req_addr  = 32'h0;
    bus.m_req_ready = 1'b1;
    #1;
    n_tests++; if (bus.i_req_ready !== 1'b1) begin n_fail++; $display("FAIL fetch_rdy got %0b exp 1", bus.i_req_ready); end
    n_tests++; if (bus.m_req_we !== 1'b0 || bus.m_req_addr !== 32'h0) begin n_fail++; $display("FAIL fetch_mreq got we=%0b a=%h exp we=0 a=0", bus.m_req_we, bus.m_req_addr); end
    tick();
    bus.i_req_valid = 1'b0;
    #1;
    n_tests++; if (outstanding !== 3'd1) begin n_fail++; $display("FAIL fetch_out1 got %0d exp 1", outstanding); end
    n_tests++; if (bus.i_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_early got %0b exp 0", bus.i_rsp_valid); end
    tick();
    bus.m_rsp_valid = 1'b1;
    bus.m_rsp_rdata = 32'h13;
    #1;
    n_tests++; if (bus.i_rsp_valid !== 1'b1 || bus.i_rsp_rdata !== 32'h13) begin n_fail++; $display("FAIL fetch_rsp got v=%0b d=%h exp v=1 d=13", bus.i_rsp_valid, bus.i_rsp_rdata); end
    n_tests++; if (bus.d_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_drsp got %0b exp 0", bus.d_rsp_valid); end
    tick();
    bus.m_rsp_valid = 1'b0;
    #1;
    n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL fetch_out0 got %0d exp 0", outstanding); end
    idle_inputs();
    tick();
  endtask

  task automatic test_both();
    bus.d_req_valid = 1'b1;
    bus.d_req_addr  = 32'h100;
    bus.i_req_valid = 1'b1;
    bus.i_req_addr  = 32'h4;
    bus.m_req_ready = 1'b1;
    #1;
    n_tests++; if (bus.d_req_ready !== 1'b1 || bus.i_req_ready !== 1'b0 || bus.m_req_addr !== 32'h100) begin n_fail++; $display("FAIL both_d got dr=%0b ir=%0b a=%h exp 1 0 100", bus.d_req_ready, bus.i_req_ready, bus.m_req_addr); end
    tick();
    bus.d_req_valid = 1'b0;
    #1;
    n_tests++; if (bus.i_req_ready !== 1'b1 || bus.m_req_addr !== 32'h4) begin n_fail++; $display("FAIL both_i got ir=%0b a=%h exp 1 4", bus.i_req_ready, bus.m_req_addr); end
    tick();
    bus.i_req_valid = 1'b0;
    bus.m_rsp_valid = 1'b1;
    bus.m_rsp_rdata = 32'hAA;
    #1;
    n_tests++; if (bus.d_rsp_valid !== 1'b1 || bus.i_rsp_valid !== 1'b0 || bus.d_rsp_rdata !== 32'hAA) begin n_fail++; $display("FAIL both_rsp1 got dv=%0b iv=%0b d=%h exp 1 0 aa", bus.d_rsp_valid, bus.i_rsp_valid, bus.d_rsp_rdata); end
    tick();
    bus.m_rsp_rdata = 32'hBB;
    #1;
    n_tests++; if (bus.i_rsp_valid !== 1'b1 || bus.d_rsp_valid !== 1'b0 || bus.i_rsp_rdata !== 32'hBB) begin n_fail++; $display("FAIL both_rsp2 got iv=%0b dv=%0b d=%h exp 1 0 bb", bus.i_rsp_valid, bus.d_rsp_valid, bus.i_rsp_rdata); end
    tick();
    idle_inputs();
    #1;
    n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL both_out got %0d exp 0", outstanding); end
    tick();
  endtask

  task automatic test_lock();
    bus.i_req_valid = 1'b1;
    bus.i_req_addr  = 32'h4;
    bus.m_req_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        bus.d_req_valid = 1'b1;
        bus.d_req_addr  = 32'h200;
      end
      #1;
      n_tests++; if (bus.m_req_valid !== 1'b1 || bus.m_req_addr !== 32'h4 || bus.d_req_ready !== 1'b0 || bus.i_req_ready !== 1'b0) begin n_fail++; $display("FAIL lock_hold%0d got v=%0b a=%h dr=%0b ir=%0b exp 1 4 0 0", c, bus.m_req_valid, bus.m_req_addr, bus.d_req_ready, bus.i_req_ready); end
      tick();
    end
    bus.m_req_ready = 1'b1;
    #1;
    n_tests++; if (bus.i_req_ready !== 1'b1 || bus.d_req_ready !== 1'b0 || bus.m_req_addr !== 32'h4) begin n_fail++; $display("FAIL lock_acc got ir=%0b dr=%0b a=%h exp 1 0 4", bus.i_req_ready, bus.d_req_ready, bus.m_req_addr); end
    tick();
    bus.i_req_valid = 1'b0;
    #1;
    n_tests++; if (bus.d_req_ready !== 1'b1 || bus.m_req_addr !== 32'h200) begin n_fail++; $display("FAIL lock_d got dr=%0b a=%h exp 1 200", bus.d_req_ready, bus.m_req_addr); end
    tick();
    bus.d_req_valid = 1'b0;
    bus.m_rsp_valid = 1'b1;
    #1;
    n_tests++; if (bus.i_rsp_valid !== 1'b1 || bus.d_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL lock_rsp1 got iv=%0b dv=%0b exp 1 0", bus.i_rsp_valid, bus.d_rsp_valid); end
    tick();
    #1;
    n_tests++; if (bus.d_rsp_valid !== 1'b1 || bus.i_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL lock_rsp2 got dv=%0b iv=%0b exp 1 0", bus.d_rsp_valid, bus.i_rsp_valid); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_starve();
    bus.d_req_valid = 1'b1;
    bus.d_req_we    = 1'b1;
    bus.i_req_valid = 1'b1;
    bus.i_req_addr  = 32'h8;
    bus.m_req_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int k = 1; k <= LIM + 1; k++) begin
        logic exp_i;
        bus.d_req_addr  = 32'h1000 + 32'(k * 4);
        bus.d_req_wdata = $urandom;
        exp_i = (k == LIM + 1);
        #1;
        n_tests++; if (bus.i_req_ready !== exp_i || bus.d_req_ready !== !exp_i) begin n_fail++; $display("FAIL starve_r%0d_k%0d got ir=%0b dr=%0b exp ir=%0b", r, k, bus.i_req_ready, bus.d_req_ready, exp_i); end
        if (exp_i) begin
          n_tests++; if (bus.m_req_addr !== 32'h8 || bus.m_req_we !== 1'b0) begin n_fail++; $display("FAIL starve_mreq got a=%h we=%0b exp 8 0", bus.m_req_addr, bus.m_req_we); end
        end
        tick();
      end
    end
    bus.d_req_valid = 1'b0;
    bus.i_req_valid = 1'b0;
    #1;
    n_tests++; if (outstanding !== 3'd2) begin n_fail++; $display("FAIL starve_out got %0d exp 2", outstanding); end
    bus.m_rsp_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_tests++; if (bus.i_rsp_valid !== 1'b1 || bus.d_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL starve_rsp%0d got iv=%0b dv=%0b exp 1 0", k, bus.i_rsp_valid, bus.d_rsp_valid); end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_full();
    bus.m_req_ready = 1'b1;
    bus.d_req_valid = 1'b1;
    bus.d_req_we    = 1'b0;
    for (int k = 0; k < MAX_OUT; k++) begin
      bus.d_req_addr = 32'h10 * 32'(k);
      #1;
      n_tests++; if (bus.d_req_ready !== 1'b1) begin n_fail++; $display("FAIL full_fill%0d got %0b exp 1", k, bus.d_req_ready); end
      tick();
    end
    bus.d_req_addr  = 32'h50;
    bus.i_req_valid = 1'b1;
    #1;
    n_tests++; if (bus.d_req_ready !== 1'b0 || bus.i_req_ready !== 1'b0 || bus.m_req_valid !== 1'b0) begin n_fail++; $display("FAIL full_block got dr=%0b ir=%0b mv=%0b exp 0 0 0", bus.d_req_ready, bus.i_req_ready, bus.m_req_valid); end
    n_tests++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL full_out4 got %0d exp 4", outstanding); end
    tick();
    bus.i_req_valid = 1'b0;
    bus.d_req_we    = 1'b1;
    #1;
    n_tests++; if (bus.d_req_ready !== 1'b1 || bus.m_req_we !== 1'b1) begin n_fail++; $display("FAIL full_wr got dr=%0b we=%0b exp 1 1", bus.d_req_ready, bus.m_req_we); end
    tick();
    bus.d_req_we    = 1'b0;
    bus.m_rsp_valid = 1'b1;
    bus.m_rsp_rdata = 32'h55;
    #1;
    n_tests++; if (bus.d_req_ready !== 1'b0 || bus.d_rsp_valid !== 1'b1 || bus.d_rsp_rdata !== 32'h55) begin n_fail++; $display("FAIL full_samepop got dr=%0b rv=%0b d=%h exp 0 1 55", bus.d_req_ready, bus.d_rsp_valid, bus.d_rsp_rdata); end
    tick();
    bus.m_rsp_valid = 1'b0;
    #1;
    n_tests++; if (bus.d_req_ready !== 1'b1 || outstanding !== 3'd3) begin n_fail++; $display("FAIL full_next got dr=%0b out=%0d exp 1 3", bus.d_req_ready, outstanding); end
    tick();
    bus.d_req_valid = 1'b0;
    #1;
    n_tests++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL full_refill got %0d exp 4", outstanding); end
    bus.m_rsp_valid = 1'b1;
    for (int k = 0; k < MAX_OUT; k++) begin
      #1;
      n_tests++; if (bus.d_rsp_valid !== 1'b1 || bus.i_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL full_drain%0d got dv=%0b iv=%0b exp 1 0", k, bus.d_rsp_valid, bus.i_rsp_valid); end
      tick();
    end
    idle_inputs();
    #1;
    n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL full_empty got %0d exp 0", outstanding); end
    tick();
  endtask

  task automatic test_err();
    bus.m_rsp_valid = 1'b1;
    bus.m_rsp_rdata = 32'hDEAD;
    #1;
    n_tests++; if (bus.d_rsp_valid !== 1'b0 || bus.i_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL err_rsp got dv=%0b iv=%0b exp 0 0", bus.d_rsp_valid, bus.i_rsp_valid); end
    tick();
    bus.m_rsp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++; if (rsp_err !== 1'b1 || outstanding !== 3'd0) begin n_fail++; $display("FAIL err_sticky%0d got err=%0b out=%0d exp 1 0", k, rsp_err, outstanding); end
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_tests++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL err_clr got %0b exp 0", rsp_err); end
    tick();
  endtask

  task automatic test_random();
    bit          q[$];
    int          lock;
    int          starve;
    bit          err;
    bit          dp, ip;
    bit          full, de, ie, gd, gi, mv, dr, ir, erv, erd, eri;
    logic [31:0] ea;
    lock   = 0;
    starve = 0;
    err    = 0;
    dp     = 0;
    ip     = 0;
    idle_inputs();
    for (int c = 0; c < 1500; c++) begin
      if (!dp && (c < 700 || $urandom_range(0, 2) != 0)) begin
        dp = 1;
        bus.d_req_we    = ($urandom_range(0, 3) == 0);
        bus.d_req_addr  = $urandom;
        bus.d_req_wdata = $urandom;
      end
      if (!ip && $urandom_range(0, 1) != 0) begin
        ip = 1;
        bus.i_req_addr = $urandom;
      end
      bus.d_req_valid = dp;
      bus.i_req_valid = ip;
      bus.m_req_ready = ($urandom_range(0, 3) != 0);
      bus.m_rsp_valid = (q.size() > 0) && ($urandom_range(0, 2) == 0);
      bus.m_rsp_rdata = $urandom;
      full = (q.size() == MAX_OUT);
      de = dp && (bus.d_req_we || !full);
      ie = ip && !full;
      if (lock == 1) begin
        gd = 1; gi = 0;
      end else if (lock == 2) begin
        gd = 0; gi = 1;
      end else begin
        gi = ie && (!de || (starve == LIM && ip));
        gd = !gi;
      end
      mv = (gd && de) || (gi && ie);
      dr = gd && de && bus.m_req_ready;
      ir = gi && ie && bus.m_req_ready;
      ea = gi ? bus.i_req_addr : bus.d_req_addr;
      erv = bus.m_rsp_valid && q.size() > 0;
      erd = erv && (q[0] == 1'b0);
      eri = erv && (q[0] == 1'b1);
      #1;
      n_tests++; if ({bus.m_req_valid, bus.d_req_ready, bus.i_req_ready} !== {mv, dr, ir}) begin n_fail++; $display("FAIL rnd_req c%0d got mv/dr/ir=%b exp %b", c, {bus.m_req_valid, bus.d_req_ready, bus.i_req_ready}, {mv, dr, ir}); end
      if (mv) begin
        n_tests++; if (bus.m_req_addr !== ea || bus.m_req_we !== (gd && bus.d_req_we)) begin n_fail++; $display("FAIL rnd_mux c%0d got a=%h we=%0b exp a=%h", c, bus.m_req_addr, bus.m_req_we, ea); end
      end
      n_tests++; if ({bus.d_rsp_valid, bus.i_rsp_valid} !== {erd, eri} || bus.d_rsp_rdata !== bus.m_rsp_rdata) begin n_fail++; $display("FAIL rnd_rsp c%0d got dv/iv=%b exp %b", c, {bus.d_rsp_valid, bus.i_rsp_valid}, {erd, eri}); end
      n_tests++; if (outstanding !== 3'(q.size()) || rsp_err !== err) begin n_fail++; $display("FAIL rnd_state c%0d got out=%0d err=%0b exp %0d %0b", c, outstanding, rsp_err, q.size(), err); end
      if (bus.m_rsp_valid) begin
        if (q.size() > 0) void'(q.pop_front());
        else err = 1;
      end
      if (dr && !bus.d_req_we) q.push_back(1'b0);
      if (ir) q.push_back(1'b1);
      if (ip && !ir) starve = (starve < LIM) ? starve + 1 : LIM;
      else starve = 0;
      if (lock != 0) begin
        if (mv && bus.m_req_ready) lock = 0;
      end else if (mv && !bus.m_req_ready) begin
        lock = gi ? 2 : 1;
      end
      if (dr) dp = 0;
      if (ir) ip = 0;
      tick();
    end
    bus.d_req_valid = 1'b0;
    bus.i_req_valid = 1'b0;
    bus.m_req_ready = 1'b0;
    for (int k = 0; k < 2 * MAX_OUT && q.size() > 0; k++) begin
      bus.m_rsp_valid = 1'b1;
      #1;
      n_tests++; if (bus.i_rsp_valid !== q[0] || bus.d_rsp_valid !== !q[0]) begin n_fail++; $display("FAIL rnd_drain%0d got iv=%0b exp %0b", k, bus.i_rsp_valid, q[0]); end
      void'(q.pop_front());
      tick();
    end
    idle_inputs();
    #1;
    n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL rnd_end got %0d exp 0", outstanding); end
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    idle_inputs();
    test_reset();
    test_fetch();
    test_both();
    test_lock();
    test_starve();
    test_full();
    test_err();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
